// File: rtl/sram_ctl_pkg.sv
// sram_ctl_pkg: shared types for the SRAM controller.
// Phase encoding, requester indices and a sizing helper.
package sram_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WSETUP,
    WPULSE,
    WHOLD,
    RACCESS,
    DONE
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
// A tie goes to the port that was not granted last.
module rr_arb2
  import sram_ctl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic last_q;
  logic any;

  // pick a winner; ties go against the last grant
  always_comb begin
    gnt_idx = PORT_CPU;
    unique case (1'b1)
      (req == 2'b11): gnt_idx = ~last_q;
      (req == 2'b10): gnt_idx = PORT_DBG;
      default:        gnt_idx = PORT_CPU;
    endcase
    any = grant_en & (|req);
    gnt = 2'b00;
    if (any) gnt = gnt_idx ? 2'b10 : 2'b01;
  end

  // remember who won; reset makes the CPU port preferred
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_DBG;
    end else if (any) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/sram_ctl.sv
// sram_ctl: two-port timed controller for an async SRAM.
// Pins are driven from flops so CE_N/WE_N never glitch.
module sram_ctl
  import sram_ctl_pkg::*;
#(
  parameter int AW      = 14,
  parameter int DW      = 49,
  parameter int SETUP   = 1,
  parameter int PULSE   = 2,
  parameter int HOLD    = 1,
  parameter int RD_WAIT = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          done0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_di,
  input  logic [DW-1:0] sram_do,
  output logic          sram_ce_n,
  output logic          sram_we_n
);

  localparam int CNT_W =
    $clog2(max4(SETUP, PULSE, HOLD, RD_WAIT)) + 1;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] LD_RD    = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [AW-1:0]    a_q;
  logic [DW-1:0]    di_q;
  logic [DW-1:0]    rdata_q;
  logic             idx_q;
  logic             ce_n_q;
  logic             we_n_q;
  logic [1:0]       gnt;
  logic             gnt_idx;
  logic             grant;
  logic             cap;
  logic             sel_we;
  logic [AW-1:0]    sel_a;
  logic [DW-1:0]    sel_d;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (reset_n),
    .req      ({req1, req0}),
    .grant_en (state_q == IDLE),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  assign grant  = |gnt;
  assign sel_we = gnt_idx ? we1    : we0;
  assign sel_a  = gnt_idx ? addr1  : addr0;
  assign sel_d  = gnt_idx ? wdata1 : wdata0;

  // phase sequencing with one shared down-counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          if (sel_we) begin
            state_d = WSETUP;
            cnt_d   = LD_SETUP;
          end else begin
            state_d = RACCESS;
            cnt_d   = LD_RD;
          end
        end
      end
      WSETUP: begin
        if (cnt_q == '0) begin
          state_d = WPULSE;
          cnt_d   = LD_PULSE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      WPULSE: begin
        if (cnt_q == '0) begin
          state_d = WHOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      WHOLD: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      RACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          cap     = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and phase counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // latch the winning request; port inputs ignored after grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      di_q  <= '0;
      idx_q <= PORT_CPU;
    end else if (grant) begin
      a_q   <= sel_a;
      di_q  <= sel_d;
      idx_q <= gnt_idx;
    end
  end

  // capture DO on the last access edge; held until next read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (cap) begin
      rdata_q <= sram_do;
    end
  end

  // strobes follow the next phase so they change with the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_n_q <= 1'b1;
      we_n_q <= 1'b1;
    end else begin
      ce_n_q <= !(state_d inside {WSETUP, WPULSE, WHOLD, RACCESS});
      we_n_q <= (state_d != WPULSE);
    end
  end

  assign sram_a    = a_q;
  assign sram_di   = di_q;
  assign sram_ce_n = ce_n_q;
  assign sram_we_n = we_n_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign done0     = (state_q == DONE) && (idx_q == PORT_CPU);
  assign done1     = (state_q == DONE) && (idx_q == PORT_DBG);

endmodule

// File: doc/sram_ctl.md
Name: sram_ctl

Overview:
- Timed, two-requester controller for one asynchronous static RAM part, such as the 16kx49 microcode store or the 1kx32 A-memory.
- Arbitrates between port 0 (CPU datapath) and port 1 (loader/debug interface).
- Drives the part's A/DI/CE_N/WE_N pins with programmable setup, pulse and hold cycle counts, and captures read data from DO.
- Writes land on the rising edge of WE_N while CE_N is low.

Parameters:
AW, 14, SRAM address width
DW, 49, SRAM data width
SETUP, 1, write cycles with address/data/CE_N valid before WE_N falls (>=1)
PULSE, 2, cycles WE_N held low (>=1)
HOLD, 1, cycles address/data/CE_N held after WE_N rises (>=1)
RD_WAIT, 2, cycles CE_N low with address valid before DO is sampled (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req0  in  1  port 0 request; held high until done0
we0  in  1  port 0: 1 = write, 0 = read
addr0  in  AW  port 0 address
wdata0  in  DW  port 0 write data
done0  out  1  one-cycle completion pulse, port 0
req1/we1/addr1/wdata1/done1  same as port 0, for port 1
rdata  out  DW  read data; valid in the done cycle and held until the next read completes
busy  out  1  high whenever state != IDLE
sram_a  out  AW  to part A
sram_di  out  DW  to part DI
sram_do  in  DW  from part DO
sram_ce_n  out  1  to part CE_N
sram_we_n  out  1  to part WE_N

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; sram_ce_n=1, sram_we_n=1, sram_a=0, sram_di=0, rdata=0, done0=done1=0, busy=0; round-robin pointer favours port 0.
- Reset mid-operation: CE_N/WE_N go high immediately (asynchronously). No done is issued, and the interrupted write may or may not have landed.
- States: IDLE, WSETUP, WPULSE, WHOLD, RACCESS, DONE. A single down-counter, CNT_W = clog2(max param)+1 bits wide, times each phase.
- IDLE:
  - Choose a port among those with req high. If only one is requesting, it wins.
  - If both are requesting, the winner is the port not granted last (round robin). The pointer updates on each grant.
  - At the grant edge, register addr, wdata, we and the granted index. Later changes on the port inputs are ignored.
  - we=1 goes to WSETUP; we=0 goes to RACCESS. CE_N goes low in the first cycle of either state.
- WSETUP: CE_N=0, WE_N=1, for SETUP cycles, then WPULSE.
- WPULSE: CE_N=0, WE_N=0, for PULSE cycles, then WHOLD.
- WHOLD: CE_N=0, WE_N=1, for HOLD cycles, then DONE. WE_N rises exactly at the WPULSE->WHOLD edge.
- RACCESS: CE_N=0, WE_N=1, for RD_WAIT cycles. At the final edge, capture sram_do into rdata and go to DONE.
- DONE: lasts one cycle.
  - CE_N=1, WE_N=1; done of the granted port is high.
  - No grant is made in this cycle, so a requester may drop req at that edge without being regranted.
  - Next state is IDLE.
- sram_a/sram_di hold the latched values from the grant through DONE.
- Latency from the grant edge to done high:
  - Write: SETUP+PULSE+HOLD cycles (defaults: 4; done is high in cycle 5 counting the grant-edge cycle as 1).
  - Read: RD_WAIT cycles (defaults: 2).
- Minimum spacing between two operations: one DONE cycle plus one IDLE cycle.
- Deasserting req before done is a protocol violation. The operation completes regardless and done still pulses.
- The done outputs are never both high. busy=0 only in IDLE.

Decomposition:
- sram_ctl_pkg holds:
  - state enum (IDLE, WSETUP, WPULSE, WHOLD, RACCESS, DONE)
  - port index constants PORT_CPU=0, PORT_DBG=1
- Sub-module rr_arb2 is a two-way round-robin arbiter with registered last-grant pointer.
  - Inputs: req[1:0], grant_en.
  - Outputs: gnt[1:0] one-hot, gnt_idx.
- Phase timing stays in sram_ctl.

Test Plan:
- Port 0 write, addr=0x0123, wdata=0x1_2345_6789_ABCD, defaults:
  - sram_ce_n low cycles 1-4 after grant.
  - sram_we_n low exactly cycles 2-3.
  - done0 high cycle 5.
  - Behavioral part model holds the value at 0x0123.
- Port 1 read of 0x0123 after the write above -> rdata=0x1_2345_6789_ABCD in the done1 cycle, held afterwards; done0 stays low.
- req0 and req1 rise in the same cycle, both writes, both held high:
  - grants in order port 0, 1, 0, 1.
  - DONE+IDLE gap of two cycles with CE_N high between operations.
- Port 0 drops req in its done0 cycle while port 1 stays idle -> no second grant; busy=0 from the next cycle.
- reset_n pulsed low during WPULSE -> sram_we_n and sram_ce_n high within the same cycle; no done; state IDLE after release.
- Parameters SETUP=2, PULSE=3, HOLD=2, RD_WAIT=1 -> write done 7 cycles after the grant edge; read done 1 cycle after the grant edge; WE_N low exactly 3 cycles.
